if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage front end. Holds the fetch PC, issues single-beat requests to instruction memory over a request/acknowledge/response interface, and presents (pc, instruction) pairs to the IF/ID pipeline register. It honours the same stall, memory-stall and flush semantics that IF/ID applies. Whenever no instruction is available it presents an all-zero bubble, the same encoding IF/ID uses for a flushed slot.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard stall; IF/ID holds
- memStall_i  in  1  data-memory stall; IF/ID holds
- redirect_i  in  1  taken branch/jump; same signal that drives IF/ID flush_i
- redirect_pc_i  in  32  redirect target
- imem_req_o  out  1  fetch request offer
- imem_addr_o  out  32  fetch address, equal to fetch_pc
- imem_ack_i  in  1  request accepted this cycle; valid only with imem_req_o
- imem_rvalid_i  in  1  one-cycle response pulse, at least 1 cycle after ack
- imem_rdata_i  in  32  instruction word
- pc_o  out  32  PC of the presented instruction, 0 for a bubble
- instruction_o  out  32  presented instruction, 0 for a bubble
- misalign_o  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- hold = stall_i | memStall_i. take = !hold & !redirect_i, meaning IF/ID latches the presented pair this edge.
- States:
  - S_IDLE (reset state)
  - S_REQ: imem_req_o = 1
  - S_WAIT: awaiting response
  - S_FULL: one-entry buffer holds an instruction
- State transitions:
  - S_IDLE -> S_REQ: unconditional on first edge.
  - S_REQ, ack -> S_WAIT.
  - S_WAIT, rvalid, not dropping: instruction bypasses to outputs this cycle. If take, fetch_pc += 4 and go to S_REQ. Otherwise capture into buffer and go to S_FULL.
  - S_FULL: buffer presented. On take, fetch_pc += 4 and go to S_REQ.
- Redirect handling: redirect_i is acted on only when hold = 0. A redirect while hold = 1 is ignored; the hazard unit keeps it asserted.
  - S_REQ, no ack: fetch_pc <= redirect_pc; stay S_REQ. The address may change while unacked.
  - S_REQ with ack, or S_WAIT without rvalid: fetch_pc <= redirect_pc; drop <= 1; go to/stay S_WAIT.
  - S_WAIT with rvalid: response discarded; fetch_pc <= redirect_pc; go to S_REQ.
  - S_FULL: buffer discarded; fetch_pc <= redirect_pc; go to S_REQ.
  - Outputs are 0 in every cycle where redirect_i = 1 and hold = 0.
- Dropped responses: rvalid while drop = 1 is not presented; drop <= 0; go to S_REQ.
- Stray responses: rvalid in S_IDLE, S_REQ or S_FULL is ignored.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: state S_IDLE, fetch_pc = RESET_PC, drop = 0, buffer invalid, misalign_o = 0. Outputs: imem_req_o = 0, imem_addr_o = RESET_PC, pc_o = 0, instruction_o = 0.
- Reset asserted mid-transaction aborts immediately; the outstanding response is lost.
- imem_addr_o is driven from a register and is stable throughout S_REQ except on a redirect edge.
- Best-case throughput: 1 instruction per 2 cycles. Cycle N: req + ack. Cycle N+1: rvalid, presented and taken. Cycle N+2: next request.
- Bypass latency: rdata to instruction_o is combinational in the rvalid cycle.
- Buffered latency: the instruction appears 1 cycle after rvalid, and stays until the first take or a redirect.
- Simultaneous hold and rvalid: captured; nothing is lost.

## Configuration
- IFU_ALIGN_CHECK_EN defined:
  - An accepted redirect with redirect_pc_i[1:0] != 0 sets misalign_o, sticky until reset.
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
- IFU_ALIGN_CHECK_EN undefined:
  - misalign_o tied 0.
  - redirect_pc_i is loaded unmodified, and low bits pass to imem_addr_o.

## Test plan
- Reset release, RESET_PC = 0x100, memory acks immediately and responds next cycle with 0x00A00093 -> first imem_req_o on edge 1, addr 0x100; instruction_o = 0x00A00093 and pc_o = 0x100 in the rvalid cycle; next request addr 0x104.
- stall_i high for 3 cycles covering rvalid (0x12345678 at 0x104) -> buffered; outputs stay 0x12345678/0x104 until stall drops; the next request (0x108) starts only after the take.
- Redirect to 0x200 while in S_WAIT, response for 0x108 arrives 2 cycles later -> response never presented; next request addr 0x200.
- Redirect to 0x300 asserted together with memStall_i for 2 cycles -> ignored while held; applied on the first cycle memStall_i = 0; request addr 0x300.
- fetch_pc = 0xFFFFFFFC, instruction taken -> next imem_addr_o = 0x00000000.
- With IFU_ALIGN_CHECK_EN, redirect to 0x402 -> imem_addr_o = 0x400, misalign_o = 1 and stays 1. Without the macro -> imem_addr_o = 0x402, misalign_o = 0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Handshake: imem_req_o offers a fetch at imem_addr_o; the request is accepted in the cycle
// imem_ack_i is high together with imem_req_o. Exactly one imem_rvalid_i pulse carrying
// imem_rdata_i answers each accepted request, at least one cycle after the accept.
interface if_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: fetch PC, single-beat imem requests, (pc, instruction) to IF/ID.
// Optional IFU_ALIGN_CHECK_EN: word-aligns redirect targets and flags misaligned ones in misalign_o.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   memStall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc_o,
  output logic [31:0]            instruction_o,
  output logic                   misalign_o,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_pc_nx;
  logic        r_drop;
  logic        w_drop_nx;
  logic [31:0] r_buf_instr;
  logic        w_capture;
  logic        w_redir_load;
  logic        w_req;
  logic [31:0] w_pc_out;
  logic [31:0] w_ins_out;
  logic [31:0] w_redir_tgt;
  logic        w_hold;
  logic        w_take;
  logic        w_redir;

  assign w_hold  = stall_i | memStall_i;
  assign w_take  = ~w_hold & ~redirect_i;
  // A redirect raised during a hold stays asserted by the hazard unit, so it is simply deferred.
  assign w_redir = redirect_i & ~w_hold;

`ifdef IFU_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_redir_tgt = {redirect_pc_i[31:2], 2'b00};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_misalign <= 1'b0;
    end else if (w_redir_load && (redirect_pc_i[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_o = r_misalign;
`else
  assign w_redir_tgt = redirect_pc_i;
  assign misalign_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop      <= 1'b0;
      r_buf_instr <= 32'h0;
    end else begin
      r_state    <= w_state_nx;
      r_fetch_pc <= w_pc_nx;
      r_drop     <= w_drop_nx;
      if (w_capture) begin
        r_buf_instr <= imem.imem_rdata_i;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_fetch_pc;
    w_drop_nx    = r_drop;
    w_capture    = 1'b0;
    w_redir_load = 1'b0;
    w_req        = 1'b0;
    w_pc_out     = 32'h0;
    w_ins_out    = 32'h0;
    case (r_state)
      S_IDLE: w_state_nx = S_REQ;
      S_REQ: begin
        w_req = 1'b1;
        if (w_redir) begin
          w_pc_nx      = w_redir_tgt;
          w_redir_load = 1'b1;
          // The accepted beat belongs to the old path; its response must be discarded.
          if (imem.imem_ack_i) begin
            w_drop_nx  = 1'b1;
            w_state_nx = S_WAIT;
          end
        end else if (imem.imem_ack_i) begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid_i) begin
          if (r_drop || w_redir) begin
            w_drop_nx  = 1'b0;
            w_state_nx = S_REQ;
            if (w_redir) begin
              w_pc_nx      = w_redir_tgt;
              w_redir_load = 1'b1;
            end
          end else begin
            w_pc_out  = r_fetch_pc;
            w_ins_out = imem.imem_rdata_i;
            if (w_take) begin
              w_pc_nx    = r_fetch_pc + 32'd4;
              w_state_nx = S_REQ;
            end else begin
              w_capture  = 1'b1;
              w_state_nx = S_FULL;
            end
          end
        end else if (w_redir) begin
          w_pc_nx      = w_redir_tgt;
          w_redir_load = 1'b1;
          w_drop_nx    = 1'b1;
        end
      end
      S_FULL: begin
        if (w_redir) begin
          w_pc_nx      = w_redir_tgt;
          w_redir_load = 1'b1;
          w_state_nx   = S_REQ;
        end else begin
          // fetch_pc only advances on take, so it is still the buffered instruction's PC.
          w_pc_out  = r_fetch_pc;
          w_ins_out = r_buf_instr;
          if (w_take) begin
            w_pc_nx    = r_fetch_pc + 32'd4;
            w_state_nx = S_REQ;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = r_fetch_pc;
  assign pc_o             = w_pc_out;
  assign instruction_o    = w_ins_out;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, reset corner sequence, and a randomized
// run checked against an instruction-stream model (sequential PCs from the last accepted redirect).
module tb_if_fetch_unit;

`ifdef IFU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk_i;
  logic        rst_i;
  logic        stall_i;
  logic        memStall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;
  logic        misalign_o;
  logic [1:0]  dbg_state_o;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .memStall_i    (memStall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (bus),
    .pc_o          (pc_o),
    .instruction_o (instruction_o),
    .misalign_o    (misalign_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks;
  int errors;

  typedef struct {
    logic        st, ms, rd;
    logic [31:0] rpc;
    logic        ack, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr, e_pc, e_ins;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h0001_0193) | 32'h0000_0003;
  endfunction

  task automatic add(input logic st, input logic ms, input logic rd, input logic [31:0] rpc,
                     input logic ack, input logic rv, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                     input logic [31:0] e_ins, input logic e_mis);
    vec_t v;
    v.st = st; v.ms = ms; v.rd = rd; v.rpc = rpc; v.ack = ack; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ins = e_ins; v.e_mis = e_mis;
    tbl.push_back(v);
  endtask

  // driver
  task automatic drive(input logic st, input logic ms, input logic rd, input logic [31:0] rpc,
                       input logic ack, input logic rv, input logic [31:0] rdata);
    stall_i           = st;
    memStall_i        = ms;
    redirect_i        = rd;
    redirect_pc_i     = rpc;
    bus.imem_ack_i    = ack;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rdata;
  endtask

  task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_mis);
    chk({tag, ".req"},  {31'b0, bus.imem_req_o}, {31'b0, e_req});
    chk({tag, ".addr"}, bus.imem_addr_o, e_addr);
    chk({tag, ".pc"},   pc_o, e_pc);
    chk({tag, ".ins"},  instruction_o, e_ins);
    chk({tag, ".mis"},  {31'b0, misalign_o}, {31'b0, e_mis});
  endtask

  logic [31:0] a402;
  logic [31:0] model_pc;
  logic        model_mis;
  logic        r_st, r_ms, r_rd, r_ack, r_rv, r_hold;
  logic [31:0] r_tgt, r_rdata, pend_data;
  int          pend;
  int          since;
  int          takes;

  initial begin
    checks = 0;
    errors = 0;
    a402 = ALIGN ? 32'h0000_0400 : 32'h0000_0402;

    //   st ms rd rpc            ack rv rdata            req addr           pc             ins            mis
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h100,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h100,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h00A00093,   0, 32'h100,        32'h100,       32'h00A00093,  0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h104,        32'h0,         32'h0,         0);
    add(1, 0, 0, 32'h0,         0, 1, 32'h12345678,   0, 32'h104,        32'h104,       32'h12345678,  0);
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h104,        32'h104,       32'h12345678,  0);
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h104,        32'h104,       32'h12345678,  0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h104,        32'h104,       32'h12345678,  0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h108,        32'h0,         32'h0,         0);
    add(0, 0, 1, 32'h200,       0, 0, 32'h0,          0, 32'h108,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h200,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         0, 1, 32'hDEADBEEF,   0, 32'h200,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h200,        32'h0,         32'h0,         0);
    add(0, 1, 1, 32'h300,       0, 1, 32'hAAAA0001,   0, 32'h200,        32'h200,       32'hAAAA0001,  0);
    add(0, 1, 1, 32'h300,       0, 0, 32'h0,          0, 32'h200,        32'h200,       32'hAAAA0001,  0);
    add(0, 0, 1, 32'h300,       0, 0, 32'h0,          0, 32'h200,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h300,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h300,        32'h0,         32'h0,         0);
    add(0, 0, 1, 32'hFFFFFFFC,  0, 0, 32'h0,          0, 32'h300,        32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h55555555,   0, 32'hFFFFFFFC,   32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'hFFFFFFFC,   32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h11110013,   0, 32'hFFFFFFFC,   32'hFFFFFFFC,  32'h11110013,  0);
    add(0, 0, 1, 32'h402,       0, 0, 32'h0,          1, 32'h0,          32'h0,         32'h0,         0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, a402,           32'h0,         32'h0,         ALIGN);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, a402,           32'h0,         32'h0,         ALIGN);
    add(0, 0, 0, 32'h0,         0, 1, 32'h22220013,   0, a402,           a402,          32'h22220013,  ALIGN);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, a402 + 32'd4,   32'h0,         32'h0,         ALIGN);

    rst_i = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    expect_out("reset", 1'b0, RST_PC, 32'h0, 32'h0, 1'b0);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].ms, tbl[i].rd, tbl[i].rpc, tbl[i].ack, tbl[i].rv, tbl[i].rdata);
      #4;
      expect_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_pc,
                 tbl[i].e_ins, tbl[i].e_mis);
      @(negedge clk_i);
    end

    // reset while a response is outstanding, then a stray response right after release
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    #4;
    expect_out("mid.acc", 1'b1, a402 + 32'd4, 32'h0, 32'h0, ALIGN);
    @(negedge clk_i);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    rst_i = 1'b0;
    #1;
    expect_out("mid.rst", 1'b0, RST_PC, 32'h0, 32'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 1, 32'h77777777);
    #4;
    expect_out("stray", 1'b0, RST_PC, 32'h0, 32'h0, 1'b0);
    @(negedge clk_i);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    #4;
    expect_out("post_rst", 1'b1, RST_PC, 32'h0, 32'h0, 1'b0);
    @(negedge clk_i);

    // randomized run against the instruction-stream model
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i     = 1'b1;
    model_pc  = RST_PC;
    model_mis = 1'b0;
    pend      = 0;
    pend_data = 32'h0;
    since     = 0;
    takes     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rv    = 1'b0;
      r_rdata = $urandom;
      if (pend == 1) begin
        r_rv    = 1'b1;
        r_rdata = pend_data;
      end
      if (pend > 0) pend--;
      r_ack = bus.imem_req_o && ($urandom_range(0, 9) < 7);
      r_st  = ($urandom_range(0, 9) < 2);
      r_ms  = ($urandom_range(0, 9) < 1);
      r_rd  = (cyc >= 2) && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       r_tgt = 32'hFFFF_FFF0;
        1:       r_tgt = ($urandom_range(0, 63) << 4) | $urandom_range(1, 3);
        default: r_tgt = $urandom_range(0, 255) << 2;
      endcase
      drive(r_st, r_ms, r_rd, r_tgt, r_ack, r_rv, r_rdata);
      #4;
      r_hold = r_st | r_ms;
      if (bus.imem_req_o) chk("rnd.addr", bus.imem_addr_o, model_pc);
      if (r_rd && !r_hold) begin
        chk("rnd.redir_pc", pc_o, 32'h0);
        chk("rnd.redir_ins", instruction_o, 32'h0);
      end else if (instruction_o != 32'h0) begin
        chk("rnd.pc", pc_o, model_pc);
        chk("rnd.ins", instruction_o, mem_word(model_pc));
        if (!r_hold) begin
          model_pc = model_pc + 32'd4;
          takes++;
          since = 0;
        end
      end else begin
        chk("rnd.bubble_pc", pc_o, 32'h0);
      end
      chk("rnd.mis", {31'b0, misalign_o}, {31'b0, model_mis});
      if (r_rd && !r_hold) begin
        model_pc = ALIGN ? {r_tgt[31:2], 2'b00} : r_tgt;
        if (ALIGN && (r_tgt[1:0] != 2'b00)) model_mis = 1'b1;
        since = 0;
      end
      if (r_ack) begin
        pend      = $urandom_range(1, 3);
        pend_data = mem_word(bus.imem_addr_o);
      end
      since++;
      if (since > 200) begin
        chk("rnd.progress", since, 32'd200);
        break;
      end
      @(negedge clk_i);
    end
    chk("rnd.takes_min", {31'b0, (takes >= 200)}, 32'd1);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
